// File: rtl/neuron_mac_if.sv
// Evaluation handshake and data bus for neuron_mac: start/pair streaming in,
// quantised result out.
interface neuron_mac_if;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] act_in;
  logic signed [7:0] weight_in;
  logic signed [15:0] bias;
  logic signed [7:0] data_out;
  logic              out_valid;
  logic              busy;

  modport master (
    output start, in_valid, act_in, weight_in, bias,
    input  in_ready, data_out, out_valid, busy
  );

  modport slave (
    input  start, in_valid, act_in, weight_in, bias,
    output in_ready, data_out, out_valid, busy
  );
endinterface

// File: rtl/neuron_mac.sv
// Single neuron multiply-accumulate: N_INPUTS signed 8x8 products plus bias,
// shifted and saturated to 8 bits. Define NEURON_MAC_RELU_EN for a ReLU output clamp.
//
// state | meaning
// IDLE  | waiting for start; last result held on data_out
// ACCUM | accepting act/weight pairs while in_valid is high
// BIAS  | adding bias to the accumulator
// OUT   | quantising; out_valid pulses on the edge leaving this state
module neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int SHIFT    = 4
) (
  input logic        clk,
  input logic        reset,
  neuron_mac_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

  localparam logic [7:0] LAST_IDX = 8'(N_INPUTS - 1);

  state_t             state;
  state_t             state_nxt;
  logic signed [23:0] acc;
  logic [7:0]         cnt;
  logic signed [7:0]  data_out_r;
  logic               out_valid_r;
  logic               in_ready_i;
  logic               busy_i;
  logic               accept;
  logic signed [15:0] prod;
  logic signed [23:0] shifted;
  logic signed [7:0]  q;

  assign accept = bus.in_valid && in_ready_i;
  assign prod   = bus.act_in * bus.weight_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ACCUM;
      ACCUM:   if (accept && cnt == LAST_IDX) state_nxt = BIAS;
      BIAS:    state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_i = 1'b0;
    busy_i     = 1'b0;
    case (state)
      IDLE:    ;
      ACCUM:   begin in_ready_i = 1'b1; busy_i = 1'b1; end
      BIAS:    busy_i = 1'b1;
      OUT:     busy_i = 1'b1;
      default: ;
    endcase
  end

  // Quantisation of the fully biased accumulator
  always_comb begin
    shifted = acc >>> SHIFT;
`ifdef NEURON_MAC_RELU_EN
    if (shifted < 0)                q = 8'sd0;
    else if (shifted > 24'sd127)    q = 8'sd127;
    else                            q = shifted[7:0];
`else
    if (shifted > 24'sd127)         q = 8'sd127;
    else if (shifted < -24'sd128)   q = -8'sd128;
    else                            q = shifted[7:0];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc         <= '0;
      cnt         <= '0;
      data_out_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc + 24'(prod);
            cnt <= cnt + 8'd1;
          end
        end
        BIAS: acc <= acc + 24'(bus.bias);
        OUT: begin
          data_out_r  <= q;
          out_valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_i;
  assign bus.busy      = busy_i;
  assign bus.data_out  = data_out_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac (N_INPUTS=4, SHIFT=4).
module tb_neuron_mac;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  neuron_mac_if bus();

  neuron_mac #(.N_INPUTS(4), .SHIFT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("in_ready_after_start", bus.in_ready, 1);
    chk("busy_after_start", bus.busy, 1);
  endtask

  // Streams four pairs; gap>0 inserts idle cycles and a start pulse between pairs.
  task automatic feed(input int a[4], input int w[4], input int gap);
    int sum;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid  = 1'b1;
      bus.act_in    = 8'(a[i]);
      bus.weight_in = 8'(w[i]);
      @(negedge clk);
      sum += a[i] * w[i];
      bus.in_valid = 1'b0;
      chk("acc_after_accept", dut.acc, sum);
      if (gap > 0 && i < 3) begin
        for (int g = 0; g < gap; g++) begin
          bus.act_in    = 8'($urandom);
          bus.weight_in = 8'($urandom);
          bus.start     = (g == 1);
          @(negedge clk);
          chk("acc_hold_gap", dut.acc, sum);
        end
        bus.start = 1'b0;
        chk("in_ready_gap", bus.in_ready, 1);
      end
    end
  endtask

  // Called at the negedge after the last accept; returns at the out_valid cycle.
  task automatic finish_eval(input int exp);
    bus.in_valid  = 1'b1;
    bus.act_in    = 8'h7f;
    bus.weight_in = 8'h7f;
    chk("in_ready_bias", bus.in_ready, 0);
    chk("out_valid_bias", bus.out_valid, 0);
    @(negedge clk);
    chk("out_valid_out_state", bus.out_valid, 0);
    chk("busy_out_state", bus.busy, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("out_valid_pulse", bus.out_valid, 1);
    chk("data_out", bus.data_out, exp);
    chk("busy_idle", bus.busy, 0);
  endtask

  task automatic idle_after(input int exp);
    @(negedge clk);
    chk("out_valid_drop", bus.out_valid, 0);
    chk("data_out_held", bus.data_out, exp);
    chk("busy_stays_low", bus.busy, 0);
  endtask

  initial begin
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.act_in    = '0;
    bus.weight_in = '0;
    bus.bias      = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_data_out", bus.data_out, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_busy", bus.busy, 0);
    reset = 1'b1;

    // in_valid in IDLE must not start anything
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("idle_in_valid_ignored", bus.busy, 0);

    // Basic evaluation: 16*(1+2+3+4)=160, >>>4 = 10
    launch();
    feed('{16, 16, 16, 16}, '{1, 2, 3, 4}, 0);
    finish_eval(10);
    idle_after(10);

    // Positive saturation: 4*127*127 = 64516, >>>4 = 4032 -> 127
    launch();
    feed('{127, 127, 127, 127}, '{127, 127, 127, 127}, 0);
    finish_eval(127);
    idle_after(127);

    // Negative result: 4*16*-4 = -256, >>>4 = -16
    launch();
    feed('{16, 16, 16, 16}, '{-4, -4, -4, -4}, 0);
`ifdef NEURON_MAC_RELU_EN
    finish_eval(0);
    idle_after(0);
`else
    finish_eval(-16);
    idle_after(-16);
`endif

    // Stalls of 3 cycles between pairs with start pulsed while busy
    launch();
    feed('{16, 16, 16, 16}, '{1, 2, 3, 4}, 3);
    finish_eval(10);
    idle_after(10);
    idle_after(10);

    // Asynchronous reset after two accepted pairs
    launch();
    bus.in_valid  = 1'b1;
    bus.act_in    = 8'sd16;
    bus.weight_in = 8'sd1;
    @(negedge clk);
    bus.weight_in = 8'sd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("acc_before_reset", dut.acc, 48);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_data_out", bus.data_out, 0);
    chk("async_reset_out_valid", bus.out_valid, 0);
    chk("async_reset_in_ready", bus.in_ready, 0);
    chk("async_reset_busy", bus.busy, 0);
    chk("async_reset_acc", dut.acc, 0);
    @(negedge clk);
    reset = 1'b1;

    // Fresh run with bias 32: (160+32)>>>4 = 12
    bus.bias = 16'sd32;
    launch();
    feed('{16, 16, 16, 16}, '{1, 2, 3, 4}, 0);
    finish_eval(12);

    // Back-to-back: start in the out_valid cycle, no idle gap
    bus.bias = 16'sd0;
    launch();
    chk("b2b_out_valid_cleared", bus.out_valid, 0);
    chk("b2b_data_out_held", bus.data_out, 12);
    feed('{127, 127, 127, 127}, '{127, 127, 127, 127}, 0);
    finish_eval(127);
    launch();
    feed('{16, 16, 16, 16}, '{-4, -4, -4, -4}, 0);
`ifdef NEURON_MAC_RELU_EN
    finish_eval(0);
    idle_after(0);
`else
    finish_eval(-16);
    idle_after(-16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4, number of activation/weight pairs per evaluation (range 1..255).
REQ-002 SHALL have parameter SHIFT, default 4, arithmetic right-shift applied before output quantisation (range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a new evaluation; sampled only in IDLE.
REQ-006 SHALL have port in_valid  input  1  act_in/weight_in pair valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts a pair this cycle; high only in ACCUM.
REQ-008 SHALL have port act_in  input  8  signed two's-complement activation.
REQ-009 SHALL have port weight_in  input  8  signed two's-complement weight.
REQ-010 SHALL have port bias  input  16  signed bias, sampled in BIAS state.
REQ-011 SHALL have port data_out  output  8  signed quantised neuron result, held until next result or reset.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse marking new data_out; directly drives a downstream register enable.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, BIAS, OUT.
REQ-015 IDLE: start=1 -> ACCUM next cycle; accumulator and pair counter cleared to 0 on that edge.
REQ-016 ACCUM: a pair is accepted on every edge where in_valid=1 and in_ready=1; acc <= acc + act_in*weight_in (signed 16-bit product, sign-extended).
REQ-017 ACCUM: in_valid=0 cycles SHALL stall with acc and counter unchanged; no timeout.
REQ-018 The edge accepting the N_INPUTS-th pair SHALL move the FSM to BIAS; in_ready SHALL be 0 from the following cycle.
REQ-019 BIAS: acc <= acc + sign-extended bias; -> OUT next edge.
REQ-020 OUT: data_out <= sat8(acc >>> SHIFT) and out_valid <= 1 on the edge leaving OUT; FSM -> IDLE; out_valid SHALL be 1 for exactly one cycle.
REQ-021 Latency: out_valid high in the 3rd cycle after the edge accepting the last pair; start-to-first-in_ready = 1 cycle.
REQ-022 Accumulator SHALL be 24 bits signed; no overflow for N_INPUTS<=255 at extreme operands.
REQ-023 sat8 SHALL clamp to [-128, 127] (see REQ-027 for ReLU variant).
REQ-024 start while busy=1 SHALL be ignored; in_valid outside ACCUM SHALL be ignored.
REQ-025 Back-to-back: start asserted in the IDLE cycle right after out_valid SHALL begin a new evaluation with no extra idle cycle.

Reset
REQ-026 reset=0 SHALL immediately (asynchronously) force IDLE, acc=0, counter=0, data_out=0, out_valid=0, in_ready=0, busy=0, including mid-ACCUM/BIAS/OUT; partial sums SHALL be discarded.

Configuration
REQ-027 Macro NEURON_MAC_RELU_EN defined: result = max(0, acc>>>SHIFT) clamped to [0, 127]; undefined: signed clamp [-128, 127], no ReLU.

Verification
REQ-028 N_INPUTS=4, SHIFT=4, bias=0, act=16,16,16,16, weight=1,2,3,4 -> data_out=10, out_valid one cycle, 3 cycles after last accept.
REQ-029 act=127, weight=127 x4, bias=0 -> acc=64516, data_out=127 (saturated).
REQ-030 act=16, weight=-4 x4, bias=0 -> with NEURON_MAC_RELU_EN data_out=0; without, data_out=-16 (0xF0).
REQ-031 Same as REQ-028 with in_valid low 3 cycles between pairs and start pulsed while busy -> data_out=10, single evaluation only, acc unchanged during gaps.
REQ-032 reset=0 for one cycle after 2 accepted pairs -> all outputs 0 immediately; new run per REQ-028 with bias=32 -> data_out=12.
REQ-033 Two evaluations back-to-back (start in cycle after out_valid) -> two out_valid pulses, correct independent results, no idle gap.
